// File: rtl/hazard_stall_unit.sv
// Hazard / stall control for the ID stage.
// Detects RAW hazards against EXE and MEM, produces the PC/IF-ID freeze plus
// the ID/EXE bubble, and holds the whole pipeline while an SRAM access in MEM
// is outstanding (with a bounded wait and a sticky timeout flag).
//
// SRAM wait FSM
//   state  | meaning
//   S_IDLE | no access outstanding; a new request that is not ready freezes now
//   S_WAIT | access outstanding; freeze until mem_ready or the wait times out
module hazard_stall_unit #(
  parameter int REG_ADDRESS_LEN = 4,
  parameter int SRAM_TIMEOUT    = 15,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_forwarding,
  input  logic                       ignore_hazard,
  input  logic                       ID_valid,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src1,
  input  logic [REG_ADDRESS_LEN-1:0] ID_src2,
  input  logic                       ID_two_src,
  input  logic                       EXE_wb_en,
  input  logic [REG_ADDRESS_LEN-1:0] EXE_dst,
  input  logic                       EXE_mem_read,
  input  logic                       MEM_wb_en,
  input  logic [REG_ADDRESS_LEN-1:0] MEM_dst,
  input  logic                       mem_req,
  input  logic                       mem_ready,
  output logic                       hazard_detected,
  output logic                       pipe_freeze,
  output logic                       mem_error,
  output logic [CNT_WIDTH-1:0]       load_stall_cnt,
  output logic [CNT_WIDTH-1:0]       mem_stall_cnt
);

  localparam int WAIT_W = (SRAM_TIMEOUT < 1) ? 1 : $clog2(SRAM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(SRAM_TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_nxt;
  logic                w_err_set;
  logic                r_mem_error;
  logic [CNT_WIDTH-1:0] r_load_cnt;
  logic [CNT_WIDTH-1:0] r_mem_cnt;

  logic w_m_exe;
  logic w_m_mem;
  logic w_load_use;
  logic w_raw_sel;
  logic w_suppress;
  logic w_raw;
  logic w_freeze_core;
  logic w_freeze;
  logic w_hazard;

  // Source-operand match terms against the EXE and MEM destinations.
  always_comb begin
    w_m_exe    = EXE_wb_en && ((EXE_dst == ID_src1) || (ID_two_src && (EXE_dst == ID_src2)));
    w_m_mem    = MEM_wb_en && ((MEM_dst == ID_src1) || (ID_two_src && (MEM_dst == ID_src2)));
    w_load_use = w_m_exe && EXE_mem_read;
    // With forwarding on only the load-use case can stall; otherwise any match stalls.
    w_raw_sel  = en_forwarding ? w_load_use : (w_m_exe || w_m_mem);
    // ignore_hazard may only hide matches the bypass network covers, never a load-use.
    w_suppress = en_forwarding && ignore_hazard && !w_load_use;
    w_raw      = ID_valid && w_raw_sel && !w_suppress;
  end

  // SRAM wait FSM: next state, wait counter and timeout detection.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_set      = 1'b0;
    w_freeze_core  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
          w_freeze_core  = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == TIMEOUT_VAL) begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = '0;
          w_err_set      = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          w_freeze_core  = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are gated by reset so they drop at once, even in the middle of a wait.
  always_comb begin
    w_freeze = rst && w_freeze_core;
    w_hazard = rst && w_raw && !w_freeze_core;
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_err_set) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  // Saturating stall performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_cnt <= '0;
      r_mem_cnt  <= '0;
    end else begin
      if (w_hazard && (r_load_cnt != '1)) begin
        r_load_cnt <= r_load_cnt + CNT_WIDTH'(1);
      end
      if (w_freeze && (r_mem_cnt != '1)) begin
        r_mem_cnt <= r_mem_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign hazard_detected = w_hazard;
  assign pipe_freeze     = w_freeze;
  assign mem_error       = r_mem_error;
  assign load_stall_cnt  = r_load_cnt;
  assign mem_stall_cnt   = r_mem_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: a reference model predicts each cycle's outputs,
// which are queued when the inputs are driven and compared against the DUT.
// A second instance with 4-bit counters exercises counter saturation cheaply.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_forwarding = 1'b0;
  logic       ignore_hazard = 1'b0;
  logic       ID_valid = 1'b0;
  logic [3:0] ID_src1 = '0;
  logic [3:0] ID_src2 = '0;
  logic       ID_two_src = 1'b0;
  logic       EXE_wb_en = 1'b0;
  logic [3:0] EXE_dst = '0;
  logic       EXE_mem_read = 1'b0;
  logic       MEM_wb_en = 1'b0;
  logic [3:0] MEM_dst = '0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;

  logic        hazard_detected, pipe_freeze, mem_error;
  logic [15:0] load_stall_cnt, mem_stall_cnt;
  logic        s_haz, s_frz, s_err;
  logic [3:0]  s_lcnt, s_mcnt;

  int checks = 0;
  int failures = 0;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .ignore_hazard(ignore_hazard),
    .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EXE_wb_en(EXE_wb_en), .EXE_dst(EXE_dst), .EXE_mem_read(EXE_mem_read),
    .MEM_wb_en(MEM_wb_en), .MEM_dst(MEM_dst), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard_detected(hazard_detected), .pipe_freeze(pipe_freeze), .mem_error(mem_error),
    .load_stall_cnt(load_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  hazard_stall_unit #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .ignore_hazard(ignore_hazard),
    .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EXE_wb_en(EXE_wb_en), .EXE_dst(EXE_dst), .EXE_mem_read(EXE_mem_read),
    .MEM_wb_en(MEM_wb_en), .MEM_dst(MEM_dst), .mem_req(mem_req), .mem_ready(mem_ready),
    .hazard_detected(s_haz), .pipe_freeze(s_frz), .mem_error(s_err),
    .load_stall_cnt(s_lcnt), .mem_stall_cnt(s_mcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic haz;
    logic frz;
    logic err;
    int   lc;
    int   mc;
    int   lc4;
    int   mc4;
  } exp_t;

  exp_t sb[$];

  // reference model state
  bit m_wait;
  int m_wcnt;
  bit m_err;
  int m_lc, m_mc, m_lc4, m_mc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_err = 0;
    m_lc = 0; m_mc = 0; m_lc4 = 0; m_mc4 = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    bit mexe, mmem, raw, frz;
    mexe = EXE_wb_en && (EXE_dst == ID_src1 || (ID_two_src && EXE_dst == ID_src2));
    mmem = MEM_wb_en && (MEM_dst == ID_src1 || (ID_two_src && MEM_dst == ID_src2));
    if (en_forwarding) raw = ID_valid && mexe && EXE_mem_read;
    else               raw = ID_valid && (mexe || mmem);
    if (!m_wait) frz = mem_req && !mem_ready;
    else         frz = !mem_ready && (m_wcnt != 15);
    e.frz = rst && frz;
    e.haz = rst && raw && !frz;
    e.err = m_err;
    e.lc = m_lc; e.mc = m_mc; e.lc4 = m_lc4; e.mc4 = m_mc4;
    return e;
  endfunction

  task automatic model_clock(input exp_t e);
    if (!rst) begin
      model_reset();
    end else begin
      if (e.haz) begin
        if (m_lc < 65535) m_lc++;
        if (m_lc4 < 15) m_lc4++;
      end
      if (e.frz) begin
        if (m_mc < 65535) m_mc++;
        if (m_mc4 < 15) m_mc4++;
      end
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin m_wait = 1; m_wcnt = 1; end
      end else if (mem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else if (m_wcnt == 15) begin
        m_wait = 0; m_wcnt = 0; m_err = 1;
      end else begin
        m_wcnt++;
      end
    end
  endtask

  // One cycle: inputs already set (at negedge); predict, queue, compare, clock.
  task automatic step();
    exp_t e, g;
    e = model_out();
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    chk("hazard", hazard_detected, g.haz);
    chk("freeze", pipe_freeze, g.frz);
    chk("mem_error", mem_error, g.err);
    chk("load_cnt", load_stall_cnt, g.lc);
    chk("mem_cnt", mem_stall_cnt, g.mc);
    chk("sat_load_cnt", s_lcnt, g.lc4);
    chk("sat_mem_cnt", s_mcnt, g.mc4);
    @(posedge clk);
    model_clock(g);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    en_forwarding = 0; ignore_hazard = 0; ID_valid = 0; ID_src1 = 0; ID_src2 = 0;
    ID_two_src = 0; EXE_wb_en = 0; EXE_dst = 0; EXE_mem_read = 0;
    MEM_wb_en = 0; MEM_dst = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    chk("rst_freeze", pipe_freeze, 0);
    chk("rst_hazard", hazard_detected, 0);
    chk("rst_err", mem_error, 0);
    chk("rst_lcnt", load_stall_cnt, 0);
    chk("rst_mcnt", mem_stall_cnt, 0);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic set_load_use();
    en_forwarding = 1; EXE_mem_read = 1; EXE_wb_en = 1; EXE_dst = 4'd3;
    ID_src1 = 4'd3; ID_valid = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // load-use with forwarding on
    set_load_use();
    #1 chk("lu_hazard", hazard_detected, 1);
    step();
    chk("lu_cnt_1", load_stall_cnt, 1);
    ignore_hazard = 1;
    #1 chk("lu_ignore_no_effect", hazard_detected, 1);
    step();
    ID_valid = 0;
    #1 chk("lu_invalid", hazard_detected, 0);
    step();

    // forwarded ALU result from MEM
    clear_inputs();
    en_forwarding = 1; MEM_wb_en = 1; MEM_dst = 4'd5; ID_src2 = 4'd5;
    ID_two_src = 1; ignore_hazard = 1; ID_valid = 1;
    #1 chk("fwd_alu", hazard_detected, 0);
    step();
    en_forwarding = 0;
    #1 chk("nofwd_alu", hazard_detected, 1);
    step();
    ID_two_src = 0;
    #1 chk("nofwd_one_src", hazard_detected, 0);
    step();
    // non-load EXE match: stalls only without forwarding
    clear_inputs();
    EXE_wb_en = 1; EXE_dst = 4'd7; ID_src1 = 4'd7; ID_valid = 1;
    step();
    en_forwarding = 1;
    step();

    // SRAM wait of 4 cycles
    clear_inputs();
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("wait_freeze", pipe_freeze, 1);
      step();
    end
    mem_ready = 1;
    #1 chk("ready_unfreeze", pipe_freeze, 0);
    step();
    mem_req = 0; mem_ready = 0;
    #1 chk("back_idle", pipe_freeze, 0);
    chk("mem_cnt_4", mem_stall_cnt, 4);
    step();
    mem_req = 1; mem_ready = 1;
    #1 chk("single_cycle", pipe_freeze, 0);
    step();

    // SRAM timeout
    clear_inputs();
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 15; i++) step();
    #1 chk("timeout_drop", pipe_freeze, 0);
    step();
    mem_req = 0;
    #1 chk("timeout_err", mem_error, 1);
    chk("timeout_cnt", mem_stall_cnt, 15);
    step();
    mem_req = 1; mem_ready = 1;
    step();
    mem_req = 0; mem_ready = 0;
    step();
    mem_req = 1;
    step();
    mem_ready = 1;
    step();
    mem_req = 0; mem_ready = 0;
    #1 chk("err_sticky", mem_error, 1);
    step();
    do_reset();
    chk("err_cleared", mem_error, 0);

    // load-use during an SRAM wait: freeze wins, hazard re-evaluated after
    clear_inputs();
    set_load_use();
    mem_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("both_haz_masked", hazard_detected, 0);
      step();
    end
    mem_ready = 1;
    #1 chk("both_haz_after", hazard_detected, 1);
    step();
    mem_req = 0; mem_ready = 0;
    #1 chk("both_lcnt", load_stall_cnt, 1);
    chk("both_mcnt", mem_stall_cnt, 2);
    step();

    // reset in the second cycle of a wait
    clear_inputs();
    do_reset();
    mem_req = 1;
    step();
    step();
    #1 chk("midwait_freeze", pipe_freeze, 1);
    do_reset();
    mem_req = 0;
    step();

    // saturation (4-bit instance) and matching 16-bit counts
    clear_inputs();
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) step();
    clear_inputs();
    mem_req = 1;
    for (int i = 0; i < 20; i++) step();
    mem_req = 0;
    #1 chk("sat_lcnt_ff", s_lcnt, 4'hF);
    chk("sat_mcnt_ff", s_mcnt, 4'hF);
    chk("lcnt_20", load_stall_cnt, 20);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Sits in ID beside the forwarding unit. It detects read-after-write hazards against instructions in EXE and MEM. It generates the PC/IF-ID freeze and the ID/EXE bubble, and it freezes the whole pipeline while an SRAM access in MEM is outstanding. The forwarding unit's ignore_hazard output feeds this block, which decides when a stall is still needed (load-use) and when it can be suppressed.

Parameters:
REG_ADDRESS_LEN, 4, width of register addresses (matches Defines.v).
SRAM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready before the error flag is raised.
CNT_WIDTH, 16, width of the stall performance counters.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-low reset.
en_forwarding  in  1  forwarding enabled (same signal that drives the forwarding unit).
ignore_hazard  in  1  from forwarding unit: a source operand is covered by forwarding.
ID_valid  in  1  ID stage holds a real instruction.
ID_src1  in  REG_ADDRESS_LEN  first source register address.
ID_src2  in  REG_ADDRESS_LEN  second source register address.
ID_two_src  in  1  instruction reads ID_src2 (register operand2 or store data).
EXE_wb_en  in  1  EXE instruction writes a register.
EXE_dst  in  REG_ADDRESS_LEN  EXE destination register.
EXE_mem_read  in  1  EXE instruction is a load.
MEM_wb_en  in  1  MEM instruction writes a register.
MEM_dst  in  REG_ADDRESS_LEN  MEM destination register.
mem_req  in  1  MEM stage is issuing an SRAM read or write this cycle.
mem_ready  in  1  SRAM reports the access is complete.
hazard_detected  out  1  freeze PC and IF/ID; insert a bubble into ID/EXE.
pipe_freeze  out  1  freeze all pipeline registers (SRAM wait).
mem_error  out  1  sticky flag: an SRAM access timed out.
load_stall_cnt  out  CNT_WIDTH  count of cycles stalled for load-use hazards.
mem_stall_cnt  out  CNT_WIDTH  count of cycles frozen for SRAM waits.

Behaviour:
- Source match terms:
  - m_exe = EXE_wb_en && (EXE_dst==ID_src1 || (ID_two_src && EXE_dst==ID_src2)).
  - m_mem is the same expression using MEM_wb_en and MEM_dst.
- Hazard when en_forwarding=0: raw = ID_valid && (m_exe || m_mem).
- Hazard when en_forwarding=1: raw = ID_valid && m_exe && EXE_mem_read (load-use only).
  - ignore_hazard may suppress only non-load matches, never the load-use term.
- hazard_detected = raw && !pipe_freeze.
  - It is combinational, valid in the same cycle.
  - While frozen, hazard_detected is forced to 0 and the bubble is deferred.
- SRAM FSM, two states, IDLE and WAIT, with a wait counter of width ceil(log2(SRAM_TIMEOUT+1)):
  - IDLE: if mem_req && !mem_ready, go to WAIT with wait counter = 1.
  - IDLE: if mem_req && mem_ready, stay in IDLE (single-cycle access, no freeze).
  - WAIT: if mem_ready, go to IDLE and clear the counter.
  - WAIT: else if counter == SRAM_TIMEOUT, go to IDLE, set mem_error=1 and clear the counter.
  - WAIT: else increment the counter.
- pipe_freeze = (state==IDLE && mem_req && !mem_ready) || (state==WAIT && !mem_ready && counter!=SRAM_TIMEOUT).
  - It is combinational, so the freeze starts in the first cycle of the access.
  - It drops in the cycle mem_ready rises, so mem_ready and the pipeline advance occur together.
- mem_error: sticky; cleared only by reset; does not block later accesses.
- Counters, both saturating at all-ones with no wrap:
  - load_stall_cnt increments on each rising edge where hazard_detected=1.
  - mem_stall_cnt increments on each edge where pipe_freeze=1.
- Simultaneous load-use hazard and SRAM wait:
  - the freeze wins;
  - the hazard is re-evaluated after the freeze;
  - only mem_stall_cnt counts.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, mem_error=0, both counters=0.
  - Outputs settle to 0 immediately, even mid-WAIT.
- A bubbled or invalid ID instruction (ID_valid=0) never stalls.

Test Plan:
- Load-use hazard, forwarding on: en_forwarding=1, EXE_mem_read=1, EXE_wb_en=1, EXE_dst=3, ID_src1=3, ID_valid=1 -> hazard_detected=1 for that cycle; load_stall_cnt goes 0->1.
- Forwarded ALU result: en_forwarding=1, MEM_wb_en=1, MEM_dst=5, ID_src2=5, ID_two_src=1, ignore_hazard=1 -> hazard_detected=0.
- Same inputs with en_forwarding=0 -> hazard_detected=1. Then set ID_two_src=0 -> hazard_detected=0.
- SRAM wait: mem_req=1 with mem_ready=0 for 4 cycles, then 1 -> pipe_freeze=1 for exactly 4 cycles and 0 on the ready cycle; mem_stall_cnt=4; state back in IDLE.
- SRAM timeout: mem_ready held at 0 -> pipe_freeze drops after SRAM_TIMEOUT=15 cycles and mem_error=1; it stays 1 across a later successful access and clears only on rst=0.
- Reset mid-WAIT and saturation: assert rst=0 in cycle 2 of a wait -> pipe_freeze=0 at once and all counters read 0. Preload mem_stall_cnt via a long freeze to 16'hFFFF -> the count stays at 16'hFFFF.
